// File: rtl/sc_types_pkg.sv
// sc_types_pkg: shared state encoding for the charge sequencer and its safety monitor
package sc_types_pkg;
    typedef enum logic [2:0] {IDLE, CHECK_GRID, CHARGING, WAIT, FAULT} state_t;
endpackage

// File: rtl/sc_charge_sequencer.sv
// sc_charge_sequencer: grid-check / charge / back-off / fault sequencer with a ramped power command
module sc_charge_sequencer
    import sc_types_pkg::*;
#(
    parameter int CHECK_CYCLES = 8,
    parameter int WAIT_CYCLES  = 64,
    parameter int MAX_RETRIES  = 3,
    parameter int STEP         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       fault_flag,
    input  logic [3:0] fault_code,
    input  logic       fault_clear,
    output state_t     current_state,
    output logic       charge_en,
    output logic [7:0] charge_level,
    output logic [1:0] retry_cnt,
    output logic [3:0] latched_code
);
    localparam int CW = $clog2(CHECK_CYCLES + 1);
    localparam int WW = $clog2(WAIT_CYCLES + 1);

    logic [CW-1:0] chk_cnt;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    target;
    state_t        nxt;
    logic          active, flt, stop, clean, chk_done, expire;
    logic [1:0]    retry_inc;
    logic [7:0]    tgt, lvl_up, lvl_dn, lvl_nxt;
    logic [8:0]    up9;

    // next-state decision and ramp arithmetic toward the target of the state being entered
    always_comb begin
        active    = current_state inside {CHECK_GRID, CHARGING, WAIT};
        flt       = fault_flag && active;
        stop      = stop_req && active;
        clean     = current_state == CHECK_GRID && fault_code == 4'b0011 && !fault_flag;
        chk_done  = clean && chk_cnt == CW'(CHECK_CYCLES - 1);
        expire    = current_state == WAIT && wait_cnt == WW'(WAIT_CYCLES - 1) && !fault_flag && !stop_req;
        retry_inc = retry_cnt + 2'd1;
        nxt       = current_state;
        if (flt)
            nxt = FAULT;
        else if (stop)
            nxt = IDLE;
        else
            case (current_state)
                IDLE:       nxt = start_req ? CHECK_GRID : IDLE;
                CHECK_GRID: nxt = fault_code == 4'b0010 ? WAIT : chk_done ? CHARGING : CHECK_GRID;
                WAIT:       nxt = !expire ? WAIT : retry_inc == 2'(MAX_RETRIES) ? FAULT : CHECK_GRID;
                FAULT:      nxt = fault_clear && !fault_flag ? IDLE : FAULT;
                default:    nxt = current_state;
            endcase
        tgt     = nxt != CHARGING ? 8'd0 :
                  fault_code == 4'b0111 ? 8'd255 :
                  fault_code == 4'b0110 ? 8'd128 : target;
        up9     = {1'b0, charge_level} + 9'(STEP);
        lvl_up  = up9 > {1'b0, tgt} ? tgt : up9[7:0];
        lvl_dn  = (charge_level - tgt) <= 8'(STEP) ? tgt : charge_level - 8'(STEP);
        lvl_nxt = charge_level < tgt ? lvl_up : charge_level > tgt ? lvl_dn : charge_level;
    end

    // state, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            current_state <= IDLE;
            charge_en     <= 1'b0;
            charge_level  <= 8'd0;
            retry_cnt     <= 2'd0;
            latched_code  <= 4'd0;
            chk_cnt       <= '0;
            wait_cnt      <= '0;
            target        <= 8'd0;
        end else begin
            current_state <= nxt;
            charge_en     <= nxt == CHARGING;
            target        <= tgt;
            charge_level  <= nxt == FAULT ? 8'd0 : lvl_nxt;
            chk_cnt       <= !clean ? '0 : chk_cnt == CW'(CHECK_CYCLES) ? chk_cnt : chk_cnt + 1'b1;
            wait_cnt      <= current_state != WAIT ? '0 : wait_cnt == WW'(WAIT_CYCLES) ? wait_cnt : wait_cnt + 1'b1;
            retry_cnt     <= (nxt == CHARGING && current_state != CHARGING) ? 2'd0 :
                             (current_state == FAULT && nxt == IDLE) ? 2'd0 :
                             expire ? retry_inc : retry_cnt;
            latched_code  <= flt ? fault_code :
                             (expire && nxt == FAULT) ? 4'b1000 :
                             (current_state == FAULT && nxt == IDLE) ? 4'd0 : latched_code;
        end
    end
endmodule

// File: tb/tb_sc_charge_sequencer.sv
// tb_sc_charge_sequencer: directed-vector bench for the charge sequencer
module tb_sc_charge_sequencer;
    import sc_types_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_req = 1'b0, stop_req = 1'b0, fault_flag = 1'b0, fault_clear = 1'b0;
    logic [3:0] fault_code = 4'd0;
    state_t     st;
    logic       charge_en;
    logic [7:0] level;
    logic [1:0] retry_cnt;
    logic [3:0] latched_code;
    int         checks = 0;
    int         errors = 0;

    sc_charge_sequencer #(.CHECK_CYCLES(3), .WAIT_CYCLES(4), .MAX_RETRIES(2), .STEP(16)) dut (
        .clk(clk), .rst(rst), .start_req(start_req), .stop_req(stop_req),
        .fault_flag(fault_flag), .fault_code(fault_code), .fault_clear(fault_clear),
        .current_state(st), .charge_en(charge_en), .charge_level(level),
        .retry_cnt(retry_cnt), .latched_code(latched_code)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int e;
        tick;
        check("rst_state", 32'(st), 32'(IDLE));
        check("rst_level", 32'(level), 0);
        check("rst_en", 32'(charge_en), 0);
        check("rst_retry", 32'(retry_cnt), 0);
        check("rst_latch", 32'(latched_code), 0);
        rst = 1'b0;
        start_req = 1'b1;
        tick;
        check("start", 32'(st), 32'(CHECK_GRID));
        start_req = 1'b0;
        fault_code = 4'b0011;
        tick;
        tick;
        check("chk_2", 32'(st), 32'(CHECK_GRID));
        tick;
        check("chk_3", 32'(st), 32'(CHARGING));
        check("chg_en", 32'(charge_en), 1);
        check("chg_lvl0", 32'(level), 0);
        fault_code = 4'b0111;
        for (int k = 1; k <= 16; k++) begin
            tick;
            check("ramp_up", 32'(level), k == 16 ? 255 : 16 * k);
        end
        tick;
        check("hold_255", 32'(level), 255);
        fault_code = 4'b0110;
        e = 255;
        for (int k = 0; k < 8; k++) begin
            e = e - 16 < 128 ? 128 : e - 16;
            tick;
            check("ramp_dn", 32'(level), 32'(e));
        end
        tick;
        check("hold_128", 32'(level), 128);
        fault_flag = 1'b1;
        fault_code = 4'b0101;
        tick;
        check("flt_state", 32'(st), 32'(FAULT));
        check("flt_level", 32'(level), 0);
        check("flt_latch", 32'(latched_code), 5);
        check("flt_en", 32'(charge_en), 0);
        fault_clear = 1'b1;
        start_req = 1'b1;
        stop_req = 1'b1;
        tick;
        check("flt_hold", 32'(st), 32'(FAULT));
        fault_flag = 1'b0;
        start_req = 1'b0;
        stop_req = 1'b0;
        tick;
        check("flt_clear", 32'(st), 32'(IDLE));
        check("clr_latch", 32'(latched_code), 0);
        fault_clear = 1'b0;
        start_req = 1'b1;
        tick;
        start_req = 1'b0;
        fault_code = 4'b0010;
        tick;
        check("wait1", 32'(st), 32'(WAIT));
        tick;
        tick;
        tick;
        check("wait1_end", 32'(st), 32'(WAIT));
        tick;
        check("retry_chk", 32'(st), 32'(CHECK_GRID));
        check("retry1", 32'(retry_cnt), 1);
        tick;
        check("wait2", 32'(st), 32'(WAIT));
        tick;
        tick;
        tick;
        check("wait2_end", 32'(st), 32'(WAIT));
        tick;
        check("retry_flt", 32'(st), 32'(FAULT));
        check("retry_code", 32'(latched_code), 8);
        check("retry2", 32'(retry_cnt), 2);
        fault_clear = 1'b1;
        tick;
        check("retry_clr", 32'(st), 32'(IDLE));
        check("retry_clr0", 32'(retry_cnt), 0);
        fault_clear = 1'b0;
        start_req = 1'b1;
        tick;
        start_req = 1'b0;
        fault_code = 4'b0011;
        tick;
        tick;
        fault_code = 4'b0000;
        tick;
        check("brk", 32'(st), 32'(CHECK_GRID));
        fault_code = 4'b0011;
        tick;
        check("brk_c1", 32'(st), 32'(CHECK_GRID));
        tick;
        check("brk_c2", 32'(st), 32'(CHECK_GRID));
        tick;
        check("brk_c3", 32'(st), 32'(CHARGING));
        fault_code = 4'b0111;
        for (int k = 0; k < 6; k++) tick;
        check("mid_96", 32'(level), 96);
        rst = 1'b1;
        tick;
        check("mid_rst", 32'(st), 32'(IDLE));
        check("mid_rst_lvl", 32'(level), 0);
        check("mid_rst_en", 32'(charge_en), 0);
        rst = 1'b0;
        start_req = 1'b1;
        tick;
        start_req = 1'b0;
        fault_code = 4'b0011;
        tick;
        tick;
        tick;
        check("chg_again", 32'(st), 32'(CHARGING));
        fault_code = 4'b0111;
        tick;
        tick;
        check("lvl_32", 32'(level), 32);
        stop_req = 1'b1;
        tick;
        check("stop_state", 32'(st), 32'(IDLE));
        check("stop_lvl", 32'(level), 16);
        stop_req = 1'b0;
        tick;
        check("stop_lvl0", 32'(level), 0);
        start_req = 1'b1;
        tick;
        start_req = 1'b0;
        stop_req = 1'b1;
        fault_flag = 1'b1;
        fault_code = 4'b0100;
        tick;
        check("both_state", 32'(st), 32'(FAULT));
        check("both_code", 32'(latched_code), 4);
        stop_req = 1'b0;
        fault_flag = 1'b0;
        fault_clear = 1'b1;
        tick;
        check("both_clr", 32'(st), 32'(IDLE));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
